id_ex_stage: RTL

- ID/EX pipeline register of the 5-stage MIPS pipeline.
- Sits directly downstream of the register file. Consumes RD1/RD2 plus the decoded ID fields and registers them for the EX stage.
- Provides write-through bypass for the same-cycle WB write, which the register file does not forward internally.
- Detects load-use hazards, drives the stall to PC/IF-ID, inserts bubbles on stall or flush, and counts stall cycles.

---
 rtl/id_ex_stage.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: WB write-through bypass, load-use hazard
// detection, bubble insertion on stall/flush and a saturating stall counter.
module id_ex_stage #(
   parameter int CTRL_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [4:0]        id_rs,
   input  logic [4:0]        id_rt,
   input  logic [4:0]        id_rd,
   input  logic              id_use_rs,
   input  logic              id_use_rt,
   input  logic              id_reg_dst,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic [31:0]       id_imm,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic [31:0]       rf_rd1,
   input  logic [31:0]       rf_rd2,
   input  logic              wb_we,
   input  logic [4:0]        wb_wa,
   input  logic [31:0]       wb_wd,
   input  logic              flush,
   output logic              stall,
   output logic              ex_valid,
   output logic [4:0]        ex_rs,
   output logic [4:0]        ex_rt,
   output logic [4:0]        ex_wa,
   output logic [31:0]       ex_a,
   output logic [31:0]       ex_b,
   output logic [31:0]       ex_imm,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic              ex_reg_write,
   output logic              ex_mem_read,
   output logic [CNT_W-1:0]  stall_cnt
);

   logic              valid_q, valid_d;
   logic [4:0]        rs_q, rs_d;
   logic [4:0]        rt_q, rt_d;
   logic [4:0]        wa_q, wa_d;
   logic [31:0]       a_q, a_d;
   logic [31:0]       b_q, b_d;
   logic [31:0]       imm_q, imm_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic              rw_q, rw_d;
   logic              mr_q, mr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic [31:0] a_in;
   logic [31:0] b_in;
   logic [4:0]  wa_in;
   logic        hazard;
   logic        rs_hit;
   logic        rt_hit;

   // The register file does not forward its own write, so bypass WB here.
   always_comb begin
      a_in = rf_rd1;
      if (id_rs == 5'd0)
         a_in = 32'd0;
      else if (wb_we && wb_wa == id_rs)
         a_in = wb_wd;
   end

   always_comb begin
      b_in = rf_rd2;
      if (id_rt == 5'd0)
         b_in = 32'd0;
      else if (wb_we && wb_wa == id_rt)
         b_in = wb_wd;
   end

   assign wa_in  = id_reg_dst ? id_rd : id_rt;
   assign rs_hit = id_use_rs && (id_rs == wa_q);
   assign rt_hit = id_use_rt && (id_rt == wa_q);
   assign hazard = valid_q && mr_q && (wa_q != 5'd0) && id_valid
                   && (rs_hit || rt_hit);
   assign stall  = hazard && !flush;

   always_comb begin
      valid_d = 1'b0;
      rs_d    = '0;
      rt_d    = '0;
      wa_d    = '0;
      a_d     = '0;
      b_d     = '0;
      imm_d   = '0;
      ctrl_d  = '0;
      rw_d    = 1'b0;
      mr_d    = 1'b0;
      if (!flush && !hazard) begin
         valid_d = id_valid;
         rs_d    = id_rs;
         rt_d    = id_rt;
         wa_d    = wa_in;
         a_d     = a_in;
         b_d     = b_in;
         imm_d   = id_imm;
         ctrl_d  = id_ctrl;
         rw_d    = id_valid && id_reg_write;
         mr_d    = id_valid && id_mem_read;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (stall && cnt_q != {CNT_W{1'b1}})
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= 1'b0;
         rs_q    <= '0;
         rt_q    <= '0;
         wa_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         imm_q   <= '0;
         ctrl_q  <= '0;
         rw_q    <= 1'b0;
         mr_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         rs_q    <= rs_d;
         rt_q    <= rt_d;
         wa_q    <= wa_d;
         a_q     <= a_d;
         b_q     <= b_d;
         imm_q   <= imm_d;
         ctrl_q  <= ctrl_d;
         rw_q    <= rw_d;
         mr_q    <= mr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign ex_valid     = valid_q;
   assign ex_rs        = rs_q;
   assign ex_rt        = rt_q;
   assign ex_wa        = wa_q;
   assign ex_a         = a_q;
   assign ex_b         = b_q;
   assign ex_imm       = imm_q;
   assign ex_ctrl      = ctrl_q;
   assign ex_reg_write = rw_q;
   assign ex_mem_read  = mr_q;
   assign stall_cnt    = cnt_q;

endmodule
